// File: rtl/rv32i_trace_pkg.sv
// Shared types and constants for the retirement trace streamer.
// Record layout, FSM states, header field positions and word counts.
// Header builder used for both the current and the next FIFO head.
package rv32i_trace_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_PC    = 3'd2,
        S_INSTR = 3'd3,
        S_RDATA = 3'd4,
        S_MADDR = 3'd5,
        S_MDATA = 3'd6
    } state_t;

    // One retired instruction as held in the FIFO (175 bits)
    typedef struct packed {
        logic [7:0]  seq;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  reg_addr;
        logic [31:0] reg_data;
        logic [31:0] mem_addr;
        logic [31:0] mem_data;
        logic        mem_wrt;
        logic        mem_read;
    } rec_t;

    localparam int REC_W = 175;

    // Header word field positions
    localparam int HDR_SYNC_LSB = 24;
    localparam int HDR_SEQ_LSB  = 16;
    localparam int HDR_WRT_BIT  = 15;
    localparam int HDR_RD_BIT   = 14;
    localparam int HDR_RDV_BIT  = 13;
    localparam int HDR_RA_LSB   = 8;
    localparam int HDR_CNT_LSB  = 0;

    // Words following the header
    localparam logic [2:0] CNT_BASE  = 3'd3;
    localparam logic [2:0] CNT_STORE = 3'd5;

    function automatic logic [31:0] mk_hdr(input logic [7:0] sync, input rec_t r);
        logic [31:0] h;
        h = '0;
        h[HDR_SYNC_LSB +: 8] = sync;
        h[HDR_SEQ_LSB +: 8]  = r.seq;
        h[HDR_WRT_BIT]       = r.mem_wrt;
        h[HDR_RD_BIT]        = r.mem_read;
        h[HDR_RDV_BIT]       = (r.reg_addr != 5'd0);
        h[HDR_RA_LSB +: 5]   = r.reg_addr;
        h[HDR_CNT_LSB +: 3]  = r.mem_wrt ? CNT_STORE : CNT_BASE;
        return h;
    endfunction

endpackage

// File: rtl/rv32i_trace_streamer_if.sv
// Outbound 32-bit word stream of the trace streamer.
// Latency: n/a (wires only).
// Backpressure: classic valid/ready; data and last held while valid & !ready.
interface rv32i_trace_streamer_if;
    logic [31:0] tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic        tx_last_o;

    modport master (output tx_data_o, output tx_valid_o, output tx_last_o, input tx_ready_i);
    modport slave  (input tx_data_o, input tx_valid_o, input tx_last_o, output tx_ready_i);
endinterface

// File: rtl/trace_fifo.sv
// Generic synchronous FIFO with level, head and next-head read ports.
// Latency: pushed entry visible at head/level the cycle after the push.
// Backpressure: push ignored when full unless a pop happens in the same cycle.
module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_dat_i,
    input  logic                     pop_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic [WIDTH-1:0]         head_o,
    output logic [WIDTH-1:0]         head_nxt_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_cnt;
    logic [AW-1:0]    w_rd_nxt;
    logic             w_pop_ok;
    logic             w_push_ok;

    assign w_pop_ok   = pop_i & (r_cnt != '0);
    assign w_push_ok  = push_i & ((r_cnt != FULL_CNT) | w_pop_ok);
    assign w_rd_nxt   = r_rd_ptr + AW'(1);
    assign full_o     = (r_cnt == FULL_CNT);
    assign empty_o    = (r_cnt == '0);
    assign level_o    = r_cnt;
    assign head_o     = r_mem[r_rd_ptr];
    assign head_nxt_o = r_mem[w_rd_nxt];

    // Storage write; contents need no reset since pointers gate visibility
    always_ff @(posedge clk_i) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= push_dat_i;
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop_ok)  r_rd_ptr <= w_rd_nxt;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
                2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end
endmodule

// File: rtl/rv32i_trace_streamer.sv
// Buffers rv32i retirements and serialises each as a 4- or 6-word burst (TRACE_PC_FILTER_EN adds a PC window).
// Latency: record pushed at edge N shows its header on tx after edge N+1; records run back to back.
// Backpressure: stream stalls hold data/last; a full FIFO drops new records and counts them.
module rv32i_trace_streamer
    import rv32i_trace_pkg::*;
#(
    parameter int         DEPTH = 8,
    parameter logic [7:0] SYNC  = 8'hA5
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     trace_en_i,
    input  logic                     retire_valid_i,
    input  logic [31:0]              pc_i,
    input  logic [31:0]              instr_i,
    input  logic [4:0]               reg_addr_i,
    input  logic [31:0]              reg_data_i,
    input  logic [31:0]              mem_addr_i,
    input  logic [31:0]              mem_data_i,
    input  logic                     mem_wrt_i,
    input  logic                     mem_read_i,
`ifdef TRACE_PC_FILTER_EN
    input  logic [31:0]              pc_lo_i,
    input  logic [31:0]              pc_hi_i,
`endif
    rv32i_trace_streamer_if.master   tx,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     overflow_o,
    output logic [15:0]              drop_cnt_o
);
    localparam int LW = $clog2(DEPTH) + 1;

    state_t       r_state;
    logic [31:0]  r_tx_dat;
    logic         r_tx_vld;
    logic         r_tx_last;
    logic [7:0]   r_seq;
    logic         r_overflow;
    logic [15:0]  r_drop_cnt;

    logic         w_in_range;
    logic         w_qual;
    logic         w_hs;
    logic         w_pop;
    logic         w_full;
    logic         w_empty;
    logic         w_drop;
    logic         w_more;
    logic [LW-1:0] w_level;
    rec_t         w_rec;
    rec_t         w_head;
    rec_t         w_head_nxt;
    state_t       w_end_state;
    logic [31:0]  w_end_dat;

`ifdef TRACE_PC_FILTER_EN
    assign w_in_range = (pc_i >= pc_lo_i) && (pc_i <= pc_hi_i);
`else
    assign w_in_range = 1'b1;
`endif

    assign w_qual = retire_valid_i & trace_en_i & w_in_range;
    assign w_hs   = r_tx_vld & tx.tx_ready_i;
    assign w_pop  = w_hs & r_tx_last;
    // Must match the FIFO's own acceptance rule so every qualified record is either stored or counted
    assign w_drop = w_qual & w_full & ~w_pop;
    assign w_rec  = {r_seq, pc_i, instr_i, reg_addr_i, reg_data_i,
                     mem_addr_i, mem_data_i, mem_wrt_i, mem_read_i};

    // The record being popped is still counted in w_level, so >1 means another is ready
    assign w_more      = (w_level > LW'(1));
    assign w_end_state = w_more ? S_HDR : S_IDLE;
    assign w_end_dat   = w_more ? mk_hdr(SYNC, w_head_nxt) : 32'd0;

    trace_fifo #(.WIDTH(REC_W), .DEPTH(DEPTH)) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (w_qual),
        .push_dat_i (w_rec),
        .pop_i      (w_pop),
        .full_o     (w_full),
        .empty_o    (w_empty),
        .level_o    (w_level),
        .head_o     (w_head),
        .head_nxt_o (w_head_nxt)
    );

    // Word serialiser: registered outputs always load the word for the state being entered
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_tx_dat  <= '0;
            r_tx_vld  <= 1'b0;
            r_tx_last <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (!w_empty) begin
                    r_state   <= S_HDR;
                    r_tx_vld  <= 1'b1;
                    r_tx_dat  <= mk_hdr(SYNC, w_head);
                    r_tx_last <= 1'b0;
                end
                S_HDR: if (w_hs) begin
                    r_state  <= S_PC;
                    r_tx_dat <= w_head.pc;
                end
                S_PC: if (w_hs) begin
                    r_state  <= S_INSTR;
                    r_tx_dat <= w_head.instr;
                end
                S_INSTR: if (w_hs) begin
                    r_state   <= S_RDATA;
                    r_tx_dat  <= w_head.reg_data;
                    r_tx_last <= ~w_head.mem_wrt;
                end
                S_RDATA: if (w_hs) begin
                    if (w_head.mem_wrt) begin
                        r_state   <= S_MADDR;
                        r_tx_dat  <= w_head.mem_addr;
                        r_tx_last <= 1'b0;
                    end else begin
                        r_state   <= w_end_state;
                        r_tx_dat  <= w_end_dat;
                        r_tx_vld  <= w_more;
                        r_tx_last <= 1'b0;
                    end
                end
                S_MADDR: if (w_hs) begin
                    r_state   <= S_MDATA;
                    r_tx_dat  <= w_head.mem_data;
                    r_tx_last <= 1'b1;
                end
                S_MDATA: if (w_hs) begin
                    r_state   <= w_end_state;
                    r_tx_dat  <= w_end_dat;
                    r_tx_vld  <= w_more;
                    r_tx_last <= 1'b0;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_tx_vld  <= 1'b0;
                    r_tx_last <= 1'b0;
                end
            endcase
        end
    end

    // Sequence number advances on every qualified retirement, kept or dropped
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)       r_seq <= '0;
        else if (w_qual) r_seq <= r_seq + 8'd1;
    end

    // Sticky overflow flag and saturating drop counter
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign tx.tx_data_o  = r_tx_dat;
    assign tx.tx_valid_o = r_tx_vld;
    assign tx.tx_last_o  = r_tx_last;
    assign level_o       = w_level;
    assign overflow_o    = r_overflow;
    assign drop_cnt_o    = r_drop_cnt;
endmodule

// File: tb/tb_rv32i_trace_streamer.sv
// Directed bench for rv32i_trace_streamer with DEPTH=8, SYNC=8'hA5.
// Covers reset, ALU/store/load bursts, overflow, random backpressure, mid-burst reset.
// The PC window scenario is compiled only when TRACE_PC_FILTER_EN is defined.
module tb_rv32i_trace_streamer;
    logic        clk = 1'b0;
    logic        rst;
    logic        trace_en;
    logic        retire_valid;
    logic [31:0] pc_v, instr_v, reg_data_v, mem_addr_v, mem_data_v;
    logic [4:0]  reg_addr_v;
    logic        mem_wrt_v, mem_read_v;
    logic [3:0]  level;
    logic        overflow;
    logic [15:0] drop_cnt;
`ifdef TRACE_PC_FILTER_EN
    logic [31:0] pc_lo, pc_hi;
`endif

    rv32i_trace_streamer_if tx_if();

    always #5 clk = ~clk;

    rv32i_trace_streamer #(.DEPTH(8), .SYNC(8'hA5)) u_dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .trace_en_i     (trace_en),
        .retire_valid_i (retire_valid),
        .pc_i           (pc_v),
        .instr_i        (instr_v),
        .reg_addr_i     (reg_addr_v),
        .reg_data_i     (reg_data_v),
        .mem_addr_i     (mem_addr_v),
        .mem_data_i     (mem_data_v),
        .mem_wrt_i      (mem_wrt_v),
        .mem_read_i     (mem_read_v),
`ifdef TRACE_PC_FILTER_EN
        .pc_lo_i        (pc_lo),
        .pc_hi_i        (pc_hi),
`endif
        .tx             (tx_if),
        .level_o        (level),
        .overflow_o     (overflow),
        .drop_cnt_o     (drop_cnt)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] cap_dat [0:63];
    logic        cap_last [0:63];
    int          cap_n, cap_cyc;
    logic [31:0] exp_q [$];

    task automatic do_reset();
        rst = 1'b1; trace_en = 1'b1; retire_valid = 1'b0;
        mem_wrt_v = 1'b0; mem_read_v = 1'b0; tx_if.tx_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // One retirement presented for exactly one rising edge
    task automatic retire(input logic [31:0] pc, input logic [31:0] ins, input logic [4:0] ra,
                          input logic [31:0] rd, input logic [31:0] ma, input logic [31:0] md,
                          input logic wr, input logic ld);
        retire_valid = 1'b1; pc_v = pc; instr_v = ins; reg_addr_v = ra; reg_data_v = rd;
        mem_addr_v = ma; mem_data_v = md; mem_wrt_v = wr; mem_read_v = ld;
        @(negedge clk);
        retire_valid = 1'b0; mem_wrt_v = 1'b0; mem_read_v = 1'b0;
    endtask

    // Gathers n handshaken words; with rnd, ready toggles randomly and stalled words must hold
    task automatic collect(input int n, input int budget, input bit rnd);
        logic pv, pr, pl;
        logic [31:0] pd;
        cap_n = 0; cap_cyc = 0; pv = 1'b0; pr = 1'b1; pl = 1'b0; pd = '0;
        while (cap_n < n && cap_cyc < budget) begin
            if (rnd && pv && !pr) begin
                checks++;
                if (tx_if.tx_valid_o !== 1'b1 || tx_if.tx_data_o !== pd || tx_if.tx_last_o !== pl) begin
                    errors++;
                    $display("FAIL stall_hold: valid=%0b data=%h last=%0b, required valid=1 data=%h last=%0b",
                             tx_if.tx_valid_o, tx_if.tx_data_o, tx_if.tx_last_o, pd, pl);
                end
            end
            if (rnd) tx_if.tx_ready_i = 1'($urandom_range(0, 1));
            if (tx_if.tx_valid_o && tx_if.tx_ready_i) begin
                cap_dat[cap_n]  = tx_if.tx_data_o;
                cap_last[cap_n] = tx_if.tx_last_o;
                cap_n++;
            end
            pv = tx_if.tx_valid_o; pr = tx_if.tx_ready_i; pd = tx_if.tx_data_o; pl = tx_if.tx_last_o;
            @(negedge clk);
            cap_cyc++;
        end
        checks++;
        if (cap_n != n) begin
            errors++;
            $display("FAIL collect_timeout: got %0d words, required %0d", cap_n, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        do_reset();
        checks++; if (tx_if.tx_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: %b required 0", tx_if.tx_valid_o); end
        checks++; if (tx_if.tx_data_o !== 32'd0) begin errors++; $display("FAIL rst_data: %h required 0", tx_if.tx_data_o); end
        checks++; if (tx_if.tx_last_o !== 1'b0) begin errors++; $display("FAIL rst_last: %b required 0", tx_if.tx_last_o); end
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL rst_level: %0d required 0", level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow: %b required 0", overflow); end
        checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL rst_drop: %0d required 0", drop_cnt); end
    endtask

    task automatic test_alu();
        logic [3:0] lasts;
        do_reset();
        tx_if.tx_ready_i = 1'b1;
        retire(32'h10, 32'h00208133, 5'd2, 32'h5, 32'h0, 32'h0, 1'b0, 1'b0);
        checks++; if (tx_if.tx_valid_o !== 1'b0) begin errors++; $display("FAIL alu_early_valid: %b required 0", tx_if.tx_valid_o); end
        checks++; if (level !== 4'd1) begin errors++; $display("FAIL alu_level: %0d required 1", level); end
        @(negedge clk);
        checks++;
        if (tx_if.tx_valid_o !== 1'b1 || tx_if.tx_data_o !== 32'hA5002203) begin
            errors++; $display("FAIL alu_latency: valid=%b data=%h required valid=1 data=a5002203", tx_if.tx_valid_o, tx_if.tx_data_o);
        end
        collect(4, 20, 1'b0);
        checks++; if (cap_dat[0] !== 32'hA5002203) begin errors++; $display("FAIL alu_w0: %h required a5002203", cap_dat[0]); end
        checks++; if (cap_dat[1] !== 32'h10) begin errors++; $display("FAIL alu_w1: %h required 00000010", cap_dat[1]); end
        checks++; if (cap_dat[2] !== 32'h00208133) begin errors++; $display("FAIL alu_w2: %h required 00208133", cap_dat[2]); end
        checks++; if (cap_dat[3] !== 32'h5) begin errors++; $display("FAIL alu_w3: %h required 00000005", cap_dat[3]); end
        lasts = {cap_last[3], cap_last[2], cap_last[1], cap_last[0]};
        checks++; if (lasts !== 4'b1000) begin errors++; $display("FAIL alu_last: %b required 1000", lasts); end
        checks++;
        if (tx_if.tx_valid_o !== 1'b0 || level !== 4'd0) begin
            errors++; $display("FAIL alu_drain: valid=%b level=%0d required valid=0 level=0", tx_if.tx_valid_o, level);
        end
    endtask

    task automatic test_store();
        logic [5:0] lasts;
        do_reset();
        tx_if.tx_ready_i = 1'b1;
        retire(32'h20, 32'h00112223, 5'd0, 32'h0, 32'h4, 32'hDEADBEEF, 1'b1, 1'b0);
        collect(6, 30, 1'b0);
        checks++; if (cap_dat[0] !== 32'hA5008005) begin errors++; $display("FAIL st_w0: %h required a5008005", cap_dat[0]); end
        checks++; if (cap_dat[1] !== 32'h20) begin errors++; $display("FAIL st_w1: %h required 00000020", cap_dat[1]); end
        checks++; if (cap_dat[4] !== 32'h4) begin errors++; $display("FAIL st_w4: %h required 00000004", cap_dat[4]); end
        checks++; if (cap_dat[5] !== 32'hDEADBEEF) begin errors++; $display("FAIL st_w5: %h required deadbeef", cap_dat[5]); end
        lasts = {cap_last[5], cap_last[4], cap_last[3], cap_last[2], cap_last[1], cap_last[0]};
        checks++; if (lasts !== 6'b100000) begin errors++; $display("FAIL st_last: %b required 100000", lasts); end
        // Disabled capture must not consume a sequence number
        trace_en = 1'b0;
        retire(32'h24, 32'h0, 5'd9, 32'h9, 32'h0, 32'h0, 1'b0, 1'b0);
        trace_en = 1'b1;
        retire(32'h28, 32'h0042a283, 5'd5, 32'h1234, 32'h42, 32'h0, 1'b0, 1'b1);
        collect(4, 20, 1'b0);
        checks++; if (cap_dat[0] !== 32'hA5016503) begin errors++; $display("FAIL ld_w0: %h required a5016503", cap_dat[0]); end
        checks++; if (cap_dat[3] !== 32'h1234 || cap_last[3] !== 1'b1) begin
            errors++; $display("FAIL ld_w3: %h last=%b required 00001234 last=1", cap_dat[3], cap_last[3]);
        end
    endtask

    task automatic test_stall();
        do_reset();
        retire_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            pc_v = 32'h1000 + 32'(4 * i); instr_v = 32'h00100093; reg_addr_v = 5'd1;
            reg_data_v = 32'(i); mem_addr_v = 32'h0; mem_data_v = 32'h0;
            @(negedge clk);
        end
        retire_valid = 1'b0;
        checks++; if (level !== 4'd8) begin errors++; $display("FAIL ovf_level: %0d required 8", level); end
        checks++; if (drop_cnt !== 16'd12) begin errors++; $display("FAIL ovf_drop: %0d required 12", drop_cnt); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: %b required 1", overflow); end
        checks++;
        if (tx_if.tx_valid_o !== 1'b1 || tx_if.tx_data_o !== 32'hA5002103) begin
            errors++; $display("FAIL ovf_held_hdr: valid=%b data=%h required valid=1 data=a5002103", tx_if.tx_valid_o, tx_if.tx_data_o);
        end
        tx_if.tx_ready_i = 1'b1;
        collect(32, 100, 1'b0);
        checks++; if (cap_cyc !== 32) begin errors++; $display("FAIL ovf_no_bubble: %0d cycles required 32", cap_cyc); end
        for (int r = 0; r < 8; r++) begin
            logic [31:0] eh;
            eh = 32'hA5002103 | (32'(r) << 16);
            checks++;
            if (cap_dat[4*r] !== eh || cap_dat[4*r+1] !== 32'h1000 + 32'(4 * r) || cap_dat[4*r+3] !== 32'(r)) begin
                errors++; $display("FAIL ovf_rec%0d: hdr=%h pc=%h rd=%h required hdr=%h pc=%h rd=%h", r,
                    cap_dat[4*r], cap_dat[4*r+1], cap_dat[4*r+3], eh, 32'h1000 + 32'(4 * r), 32'(r));
            end
        end
        retire(32'h2000, 32'h00100093, 5'd1, 32'h99, 32'h0, 32'h0, 1'b0, 1'b0);
        collect(4, 20, 1'b0);
        checks++; if (cap_dat[0] !== 32'hA5142103) begin errors++; $display("FAIL ovf_next_seq: %h required a5142103", cap_dat[0]); end
        checks++; if (drop_cnt !== 16'd12 || overflow !== 1'b1) begin
            errors++; $display("FAIL ovf_sticky: drop=%0d ovf=%b required 12 1", drop_cnt, overflow);
        end
    endtask

    task automatic add_rec(input logic [7:0] seq, input logic [31:0] pc, input logic [31:0] ins,
                           input logic [4:0] ra, input logic [31:0] rd, input logic [31:0] ma,
                           input logic [31:0] md, input logic wr, input logic ld);
        exp_q.push_back({8'hA5, seq, wr, ld, (ra != 5'd0), ra, 5'd0, (wr ? 3'd5 : 3'd3)});
        exp_q.push_back(pc);
        exp_q.push_back(ins);
        exp_q.push_back(rd);
        if (wr) begin
            exp_q.push_back(ma);
            exp_q.push_back(md);
        end
        retire(pc, ins, ra, rd, ma, md, wr, ld);
    endtask

    task automatic test_random();
        int n;
        do_reset();
        exp_q.delete();
        add_rec(8'd0, 32'h40, 32'h003100b3, 5'd3, 32'h33, 32'h0, 32'h0, 1'b0, 1'b0);
        add_rec(8'd1, 32'h44, 32'h0041a023, 5'd0, 32'h0, 32'h80, 32'h12345678, 1'b1, 1'b0);
        add_rec(8'd2, 32'h48, 32'h0001a003, 5'd0, 32'h0, 32'h84, 32'h0, 1'b0, 1'b1);
        add_rec(8'd3, 32'h4C, 32'h0071a423, 5'd7, 32'h77, 32'h88, 32'hCAFEF00D, 1'b1, 1'b0);
        n = exp_q.size();
        collect(n, 400, 1'b1);
        for (int i = 0; i < n; i++) begin
            checks++;
            if (cap_dat[i] !== exp_q[i]) begin
                errors++; $display("FAIL rnd_word%0d: %h required %h", i, cap_dat[i], exp_q[i]);
            end
        end
        tx_if.tx_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (level !== 4'd0 || tx_if.tx_valid_o !== 1'b0) begin
            errors++; $display("FAIL rnd_drain: level=%0d valid=%b required 0 0", level, tx_if.tx_valid_o);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        tx_if.tx_ready_i = 1'b1;
        retire(32'h300, 32'h00500113, 5'd2, 32'h5, 32'h0, 32'h0, 1'b0, 1'b0);
        retire(32'h304, 32'h00500113, 5'd2, 32'h6, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (tx_if.tx_data_o !== 32'h300) begin errors++; $display("FAIL mid_w1: %h required 00000300", tx_if.tx_data_o); end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (tx_if.tx_valid_o !== 1'b0) begin errors++; $display("FAIL mid_valid: %b required 0", tx_if.tx_valid_o); end
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL mid_level: %0d required 0", level); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        retire(32'h400, 32'h00500113, 5'd2, 32'h5, 32'h0, 32'h0, 1'b0, 1'b0);
        collect(4, 20, 1'b0);
        checks++; if (cap_dat[0] !== 32'hA5002203 || cap_dat[1] !== 32'h400) begin
            errors++; $display("FAIL mid_restart: hdr=%h pc=%h required a5002203 00000400", cap_dat[0], cap_dat[1]);
        end
    endtask

`ifdef TRACE_PC_FILTER_EN
    task automatic test_filter();
        do_reset();
        pc_lo = 32'h100; pc_hi = 32'h1FC;
        retire(32'hFC,  32'h13, 5'd1, 32'h1, 32'h0, 32'h0, 1'b0, 1'b0);
        retire(32'h100, 32'h13, 5'd1, 32'h2, 32'h0, 32'h0, 1'b0, 1'b0);
        retire(32'h200, 32'h13, 5'd1, 32'h3, 32'h0, 32'h0, 1'b0, 1'b0);
        checks++; if (level !== 4'd1) begin errors++; $display("FAIL flt_level: %0d required 1", level); end
        tx_if.tx_ready_i = 1'b1;
        collect(4, 20, 1'b0);
        checks++; if (cap_dat[0] !== 32'hA5002103 || cap_dat[1] !== 32'h100) begin
            errors++; $display("FAIL flt_rec: hdr=%h pc=%h required a5002103 00000100", cap_dat[0], cap_dat[1]);
        end
        checks++; if (drop_cnt !== 16'd0 || tx_if.tx_valid_o !== 1'b0) begin
            errors++; $display("FAIL flt_tail: drop=%0d valid=%b required 0 0", drop_cnt, tx_if.tx_valid_o);
        end
    endtask
`endif

    initial begin
        rst = 1'b1; trace_en = 1'b1; retire_valid = 1'b0;
        pc_v = '0; instr_v = '0; reg_addr_v = '0; reg_data_v = '0;
        mem_addr_v = '0; mem_data_v = '0; mem_wrt_v = 1'b0; mem_read_v = 1'b0;
        tx_if.tx_ready_i = 1'b0;
`ifdef TRACE_PC_FILTER_EN
        pc_lo = 32'h0; pc_hi = 32'hFFFF_FFFF;
`endif
        test_reset();
        test_alu();
        test_store();
        test_stall();
        test_random();
        test_reset_mid();
`ifdef TRACE_PC_FILTER_EN
        test_filter();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
